// File: rtl/conv_mac_array.sv
// Multi-channel, multi-filter convolution MAC engine with runtime-loaded weights and biases.
// It has a three-stage pipeline: tap products, per-filter sum, then bias/requantise/ReLU/saturate.
module conv_mac_array #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int BIAS_WIDTH   = 16,
    parameter int KERNEL_SIZE  = 3,
    parameter int IN_CHANNEL   = 3,
    parameter int NUM_FILTERS  = 4,
    parameter int OUTPUT_WIDTH = 16,
    parameter int SHIFT_WIDTH  = 5
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    cfg_wr_en,
    input  logic [$clog2(NUM_FILTERS*IN_CHANNEL*KERNEL_SIZE*KERNEL_SIZE+NUM_FILTERS)-1:0] cfg_wr_addr,
    input  logic [BIAS_WIDTH-1:0]                                   cfg_wr_data,
    input  logic                                                    cfg_commit,
    input  logic                                                    cfg_reconfig,
    input  logic [SHIFT_WIDTH-1:0]                                  quant_shift,
    input  logic                                                    relu_en,
    input  logic                                                    in_valid,
    output logic                                                    in_ready,
    input  logic [IN_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] in_window,
    output logic                                                    out_valid,
    input  logic                                                    out_ready,
    output logic [NUM_FILTERS*OUTPUT_WIDTH-1:0]                     out_data,
    output logic [1:0]                                              cfg_state
);

    localparam int TAPS       = IN_CHANNEL * KERNEL_SIZE * KERNEL_SIZE;
    localparam int NW         = NUM_FILTERS * TAPS;
    localparam int ACC_WIDTH  = DATA_WIDTH + WEIGHT_WIDTH + 1 + $clog2(TAPS) + 1;
    localparam int ADDR_WIDTH = $clog2(NW + NUM_FILTERS);
    localparam int PROD_WIDTH = DATA_WIDTH + 1 + WEIGHT_WIDTH;
    localparam int MAX_AB     = (ACC_WIDTH > BIAS_WIDTH) ? ACC_WIDTH : BIAS_WIDTH;
    localparam int MAX_ABO    = (MAX_AB > OUTPUT_WIDTH) ? MAX_AB : OUTPUT_WIDTH;
    localparam int V_WIDTH    = MAX_ABO + 2;

    localparam logic signed [V_WIDTH-1:0] SAT_MAX =
        {{(V_WIDTH-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [V_WIDTH-1:0] SAT_MIN =
        {{(V_WIDTH-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_CFG   = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    state_e state_q, state_d;

    logic signed [WEIGHT_WIDTH-1:0] wgt_q  [NW];
    logic signed [BIAS_WIDTH-1:0]   bias_q [NUM_FILTERS];
    logic [SHIFT_WIDTH-1:0]         shift_q;
    logic                           relu_q;

    logic                           vld_p1_q, vld_p2_q, vld_p3_q;
    logic                           adv_p1, adv_p2, adv_p3, in_fire;
    logic signed [PROD_WIDTH-1:0]   prod_d    [NW];
    logic signed [PROD_WIDTH-1:0]   prod_p1_q [NW];
    logic signed [ACC_WIDTH-1:0]    sum_d     [NUM_FILTERS];
    logic signed [ACC_WIDTH-1:0]    sum_p2_q  [NUM_FILTERS];
    logic [NUM_FILTERS*OUTPUT_WIDTH-1:0] res_d, res_p3_q;

    function automatic logic signed [PROD_WIDTH-1:0] tap_mul(
        input logic [DATA_WIDTH-1:0] px, input logic signed [WEIGHT_WIDTH-1:0] w);
        logic signed [PROD_WIDTH-1:0] a, b;
        a = $signed({{(PROD_WIDTH-DATA_WIDTH){1'b0}}, px});
        b = PROD_WIDTH'(w);
        return a * b;
    endfunction

    // floor((v + 2^(sh-1)) / 2^sh) == (v >>> sh) + bit (sh-1) of v, with no wide adder
    function automatic logic signed [V_WIDTH-1:0] round_shift(
        input logic signed [V_WIDTH-1:0] v, input logic [SHIFT_WIDTH-1:0] sh);
        logic signed [V_WIDTH-1:0] q, half;
        if (sh == '0) return v;
        q    = v >>> sh;
        half = v >>> (sh - SHIFT_WIDTH'(1));
        return q + $signed({{(V_WIDTH-1){1'b0}}, half[0]});
    endfunction

    function automatic logic signed [OUTPUT_WIDTH-1:0] saturate(input logic signed [V_WIDTH-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[OUTPUT_WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[OUTPUT_WIDTH-1:0];
        return v[OUTPUT_WIDTH-1:0];
    endfunction

    function automatic logic signed [OUTPUT_WIDTH-1:0] requant(
        input logic signed [ACC_WIDTH-1:0] acc, input logic signed [BIAS_WIDTH-1:0] b,
        input logic [SHIFT_WIDTH-1:0] sh, input logic relu);
        logic signed [V_WIDTH-1:0] v;
        v = V_WIDTH'(acc) + V_WIDTH'(b);
        v = round_shift(v, sh);
        if (relu && v[V_WIDTH-1]) v = '0;
        return saturate(v);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_CFG;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CFG:   if (cfg_commit) state_d = ST_RUN;
            ST_RUN:   if (cfg_reconfig) state_d = ST_DRAIN;
            ST_DRAIN: if (!(vld_p1_q || vld_p2_q || vld_p3_q)) state_d = ST_CFG;
            default:  state_d = ST_CFG;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_RUN) && adv_p1;
        cfg_state = state_q;
    end

    // Configuration is only writable in CFG, so in-flight beats never see a weight change
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NW; i++) wgt_q[i] <= '0;
            for (int f = 0; f < NUM_FILTERS; f++) bias_q[f] <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
        end else if (state_q == ST_CFG) begin
            if (cfg_wr_en) begin
                for (int i = 0; i < NW; i++)
                    if (cfg_wr_addr == ADDR_WIDTH'(i)) wgt_q[i] <= cfg_wr_data[WEIGHT_WIDTH-1:0];
                for (int f = 0; f < NUM_FILTERS; f++)
                    if (cfg_wr_addr == ADDR_WIDTH'(NW + f)) bias_q[f] <= cfg_wr_data;
            end
            if (cfg_commit) begin
                shift_q <= quant_shift;
                relu_q  <= relu_en;
            end
        end
    end

    assign adv_p3  = out_ready || !vld_p3_q;
    assign adv_p2  = adv_p3 || !vld_p2_q;
    assign adv_p1  = adv_p2 || !vld_p1_q;
    assign in_fire = in_valid && in_ready;

    // Stage 1: every tap of every filter multiplied in parallel
    always_comb begin
        for (int i = 0; i < NW; i++) prod_d[i] = '0;
        for (int f = 0; f < NUM_FILTERS; f++)
            for (int t = 0; t < TAPS; t++)
                prod_d[f*TAPS+t] = tap_mul(in_window[t*DATA_WIDTH +: DATA_WIDTH], wgt_q[f*TAPS+t]);
    end

    // Stage 2: per-filter reduction; ACC_WIDTH has headroom for the worst case
    always_comb begin
        for (int f = 0; f < NUM_FILTERS; f++) begin
            sum_d[f] = '0;
            for (int t = 0; t < TAPS; t++)
                sum_d[f] = sum_d[f] + ACC_WIDTH'(prod_p1_q[f*TAPS+t]);
        end
    end

    // Stage 3: bias, requantise, ReLU, saturate
    always_comb begin
        res_d = '0;
        for (int f = 0; f < NUM_FILTERS; f++)
            res_d[f*OUTPUT_WIDTH +: OUTPUT_WIDTH] = requant(sum_p2_q[f], bias_q[f], shift_q, relu_q);
    end

    always_ff @(posedge clk) begin
        if (in_fire)
            for (int i = 0; i < NW; i++) prod_p1_q[i] <= prod_d[i];
        if (adv_p2 && vld_p1_q)
            for (int f = 0; f < NUM_FILTERS; f++) sum_p2_q[f] <= sum_d[f];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            res_p3_q <= '0;
        end else begin
            if (adv_p1) vld_p1_q <= in_fire;
            if (adv_p2) vld_p2_q <= vld_p1_q;
            if (adv_p3) begin
                vld_p3_q <= vld_p2_q;
                if (vld_p2_q) res_p3_q <= res_d;
            end
        end
    end

    assign out_valid = vld_p3_q;
    assign out_data  = res_p3_q;

endmodule

// File: tb/tb_conv_mac_array.sv
// Self-checking bench for conv_mac_array. It uses fixed vectors, hand-written corner sequences,
// and random streams, all scored against a plain-arithmetic reference model.
module tb_conv_mac_array;
    localparam int DW = 8, WW = 8, BW = 16, K = 3, C = 3, F = 4, OW = 16, SW = 5;
    localparam int TAPS = C*K*K, NW = F*TAPS, AW = $clog2(NW+F);
    localparam int WINW = TAPS*DW, OUTW = F*OW;

    logic clk, rst, cfg_wr_en, cfg_commit, cfg_reconfig, relu_en;
    logic [AW-1:0] cfg_wr_addr;
    logic [BW-1:0] cfg_wr_data;
    logic [SW-1:0] quant_shift;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [WINW-1:0] in_window;
    logic [OUTW-1:0] out_data;
    logic [1:0] cfg_state;

    conv_mac_array #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .BIAS_WIDTH(BW), .KERNEL_SIZE(K),
                     .IN_CHANNEL(C), .NUM_FILTERS(F), .OUTPUT_WIDTH(OW), .SHIFT_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data), .cfg_commit(cfg_commit), .cfg_reconfig(cfg_reconfig),
        .quant_shift(quant_shift), .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready),
        .in_window(in_window), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .cfg_state(cfg_state));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int mw [NW];
    int mb [F];
    int msh, mrelu;
    logic [OUTW-1:0] expq [$];
    int ntests = 0, nfail = 0, n_out = 0;
    logic prev_stall = 1'b0;
    logic [OUTW-1:0] prev_data = '0;
    logic fired;

    typedef struct {
        string name;
        int wall; int w0; int b0; int sh; int relu; int pix; int exp0; int expr;
    } vec_t;
    vec_t vecs [8];

    function automatic logic [OUTW-1:0] model(input logic [WINW-1:0] win);
        logic [OUTW-1:0] r;
        longint v, hi, lo;
        r  = '0;
        hi = (longint'(1) << (OW-1)) - 1;
        lo = -(longint'(1) << (OW-1));
        for (int f = 0; f < F; f++) begin
            v = 0;
            for (int t = 0; t < TAPS; t++)
                v += longint'(win[t*DW +: DW]) * longint'(mw[f*TAPS+t]);
            v += longint'(mb[f]);
            if (msh > 0) v = (v + (longint'(1) << (msh-1))) >>> msh;
            if (mrelu != 0 && v < 0) v = 0;
            if (v > hi) v = hi;
            if (v < lo) v = lo;
            r[f*OW +: OW] = v[OW-1:0];
        end
        return r;
    endfunction

    task automatic chk_i(input string nm, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic [OUTW-1:0] act, input logic [OUTW-1:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: accepted windows queue their expected result, output handshakes pop in order
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk_i("stall_valid", int'(out_valid), 1);
                chk_b("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (expq.size() == 0) begin
                    ntests++; nfail++;
                    $display("FAIL unexpected_output: got %0h, expected no beat", out_data);
                end else begin
                    chk_b("scoreboard", out_data, expq.pop_front());
                end
            end
            if (in_valid && in_ready) expq.push_back(model(in_window));
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic tick(output logic f);
        @(negedge clk);
        f = in_valid && in_ready;
        @(posedge clk); #1;
    endtask

    task automatic model_write(input int addr, input int data);
        logic [BW-1:0] d;
        d = BW'(data);
        if (addr < NW) mw[addr] = int'($signed(d[WW-1:0]));
        else if (addr < NW+F) mb[addr-NW] = int'($signed(d));
    endtask

    task automatic wr(input int addr, input int data, input bit upd);
        cfg_wr_en = 1'b1; cfg_wr_addr = AW'(addr); cfg_wr_data = BW'(data);
        step();
        cfg_wr_en = 1'b0;
        if (upd) model_write(addr, data);
    endtask

    task automatic commit(input int sh, input int relu, input bit wr_too, input int addr, input int data);
        cfg_commit = 1'b1; quant_shift = SW'(sh); relu_en = (relu != 0);
        if (wr_too) begin
            cfg_wr_en = 1'b1; cfg_wr_addr = AW'(addr); cfg_wr_data = BW'(data);
        end
        step();
        cfg_commit = 1'b0; cfg_wr_en = 1'b0;
        quant_shift = ~quant_shift; relu_en = ~relu_en;
        msh = sh; mrelu = relu;
        if (wr_too) model_write(addr, data);
        chk_i("commit_state", int'(cfg_state), 1);
    endtask

    task automatic go_cfg();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        if (cfg_state == 2'b01) begin
            cfg_reconfig = 1'b1; step(); cfg_reconfig = 1'b0;
        end
        for (int i = 0; i < 64 && cfg_state != 2'b00; i++) step();
        chk_i("reach_cfg", int'(cfg_state), 0);
        chk_i("cfg_in_ready", int'(in_ready), 0);
    endtask

    task automatic wait_empty();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 100 && expq.size() != 0; i++) step();
        step();
        chk_i("drain_empty", expq.size(), 0);
    endtask

    task automatic load_random();
        for (int a = 0; a < NW; a++) wr(a, int'($urandom_range(0, 255)) - 128, 1'b1);
        for (int f = 0; f < F; f++) wr(NW+f, int'($urandom_range(0, 4000)) - 2000, 1'b1);
    endtask

    function automatic logic [WINW-1:0] fill(input int pix);
        logic [WINW-1:0] w;
        for (int t = 0; t < TAPS; t++) w[t*DW +: DW] = DW'(pix);
        return w;
    endfunction

    function automatic logic [WINW-1:0] rand_win();
        logic [WINW-1:0] w;
        for (int t = 0; t < TAPS; t++) w[t*DW +: DW] = DW'($urandom_range(0, 255));
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WINW-1:0] wins [6];
        int idx, n0, sent;

        vecs[0] = '{"all_ones",      1,    1,   0, 0, 0,   2,     54,     54};
        vecs[1] = '{"neg_f0_bias",   1,   -1,  10, 0, 0,   1,    -17,     27};
        vecs[2] = '{"neg_f0_relu",   1,   -1,  10, 0, 1,   1,      0,     27};
        vecs[3] = '{"sat_pos",     127,  127,   0, 0, 0, 255,  32767,  32767};
        vecs[4] = '{"shift5_round",127,  127,   0, 5, 0, 255,  27325,  27325};
        vecs[5] = '{"neg_round",    -1,   -1,   0, 2, 0,   1,     -7,     -7};
        vecs[6] = '{"sat_neg",    -128, -128,   0, 0, 0, 255, -32768, -32768};
        vecs[7] = '{"relu_shift",   -1,    1,  -3, 1, 1,   1,     12,      0};

        for (int i = 0; i < NW; i++) mw[i] = 0;
        for (int f = 0; f < F; f++) mb[f] = 0;
        msh = 0; mrelu = 0;
        rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        cfg_commit = 1'b0; cfg_reconfig = 1'b0; quant_shift = '0; relu_en = 1'b0;
        in_valid = 1'b0; in_window = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_i("rst_state", int'(cfg_state), 0);
        chk_i("rst_in_ready", int'(in_ready), 0);
        chk_i("rst_out_valid", int'(out_valid), 0);
        chk_b("rst_out_data", out_data, '0);
        rst = 1'b0;
        step();

        // Fixed vectors: constant weights and pixels with hand-computed results and latency
        for (int i = 0; i < 8; i++) begin
            go_cfg();
            for (int f = 0; f < F; f++)
                for (int t = 0; t < TAPS; t++)
                    wr(f*TAPS+t, (f == 0) ? vecs[i].w0 : vecs[i].wall, 1'b1);
            for (int f = 1; f < F; f++) wr(NW+f, 0, 1'b1);
            commit(vecs[i].sh, vecs[i].relu, 1'b1, NW, vecs[i].b0);
            in_window = fill(vecs[i].pix); in_valid = 1'b1;
            tick(fired);
            in_valid = 1'b0;
            chk_i({vecs[i].name, "_accept"}, int'(fired), 1);
            chk_i({vecs[i].name, "_lat1"}, int'(out_valid), 0);
            step();
            chk_i({vecs[i].name, "_lat2"}, int'(out_valid), 0);
            step();
            chk_i({vecs[i].name, "_lat3"}, int'(out_valid), 1);
            for (int f = 0; f < F; f++)
                chk_i($sformatf("%s_f%0d", vecs[i].name, f), int'($signed(out_data[f*OW +: OW])),
                      (f == 0) ? vecs[i].exp0 : vecs[i].expr);
            step();
        end

        // Backpressure: a stalled output fills exactly three stages, then in_ready drops
        go_cfg();
        load_random();
        commit(3, 0, 1'b0, 0, 0);
        for (int i = 0; i < 6; i++) wins[i] = rand_win();
        n0 = n_out; idx = 0; out_ready = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = 1'b1; in_window = wins[idx];
            tick(fired);
            if (fired) idx++;
        end
        chk_i("bp_accepts", idx, 3);
        chk_i("bp_in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
            in_valid = 1'b1; in_window = wins[idx];
            tick(fired);
            if (fired) idx++;
        end
        in_valid = 1'b0;
        chk_i("bp_all_sent", idx, 6);
        wait_empty();
        chk_i("bp_out_count", n_out - n0, 6);

        // Reconfigure with two beats in flight; writes and commits outside CFG are ignored
        go_cfg();
        load_random();
        commit(2, 1, 1'b0, 0, 0);
        n0 = n_out;
        in_valid = 1'b1; in_window = rand_win();
        cfg_wr_en = 1'b1; cfg_wr_addr = AW'(0); cfg_wr_data = BW'(77);
        tick(fired);
        cfg_wr_en = 1'b0;
        chk_i("rc_accept0", int'(fired), 1);
        in_window = rand_win(); cfg_reconfig = 1'b1;
        tick(fired);
        cfg_reconfig = 1'b0;
        chk_i("rc_accept1", int'(fired), 1);
        chk_i("rc_state_drain", int'(cfg_state), 2);
        in_window = rand_win();
        chk_i("rc_in_ready", int'(in_ready), 0);
        cfg_wr_en = 1'b1; cfg_wr_addr = AW'(NW); cfg_wr_data = BW'(500); cfg_commit = 1'b1;
        step();
        cfg_wr_en = 1'b0; cfg_commit = 1'b0; in_valid = 1'b0;
        chk_i("rc_commit_ignored", int'(cfg_state), 2);
        for (int i = 0; i < 20 && cfg_state != 2'b00; i++) step();
        chk_i("rc_back_to_cfg", int'(cfg_state), 0);
        chk_i("rc_out_count", n_out - n0, 2);
        commit(2, 1, 1'b0, 0, 0);
        in_valid = 1'b1; in_window = rand_win();
        tick(fired);
        in_valid = 1'b0;
        wait_empty();

        // Random streams with random valid/ready against the reference model
        for (int r = 0; r < 2; r++) begin
            go_cfg();
            load_random();
            commit(int'($urandom_range(0, 12)), int'($urandom_range(0, 1)), 1'b0, 0, 0);
            sent = 0;
            for (int cyc = 0; cyc < 400 && sent < 60; cyc++) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 6);
                in_window = rand_win();
                tick(fired);
                if (fired) sent++;
            end
            chk_i("rand_sent", sent, 60);
            wait_empty();
        end

        // Reset with beats in flight discards them and clears all configuration
        out_ready = 1'b1;
        in_valid = 1'b1; in_window = rand_win();
        tick(fired);
        in_window = rand_win();
        tick(fired);
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NW; i++) mw[i] = 0;
        for (int f = 0; f < F; f++) mb[f] = 0;
        msh = 0; mrelu = 0;
        chk_i("mrst_out_valid", int'(out_valid), 0);
        chk_i("mrst_in_ready", int'(in_ready), 0);
        chk_i("mrst_state", int'(cfg_state), 0);
        chk_b("mrst_out_data", out_data, '0);
        commit(0, 0, 1'b0, 0, 0);
        in_valid = 1'b1; in_window = fill(5);
        tick(fired);
        in_valid = 1'b0;
        chk_i("mrst_accept", int'(fired), 1);
        step(); step();
        chk_i("mrst_valid", int'(out_valid), 1);
        chk_b("mrst_zero", out_data, '0);
        wait_empty();
        chk_i("final_queue", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
